phrase_stacker: RTL and testbench

Parametrised AXI-Stream width up-converter that packs N = OUT_WIDTH/IN_WIDTH consecutive input beats into one output phrase, least-significant lane first. It sits between the pixel/depth pipeline and the MIG write path, and generalises the fixed 32→128 stacker. It sustains one input beat per cycle under backpressure. With the flush feature compiled in, a `tlast` on a partial phrase emits that phrase zero-padded, with a lane-valid mask.

---
 rtl/stacker_pkg.sv | 34 +++
 rtl/phrase_stacker.sv | 126 ++++++++++++
 tb/tb_phrase_stacker.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stacker_pkg.sv
// ============================================================================
// Module   : stacker_pkg
// Purpose  : Shared constants and helpers for the phrase stacker.
//            MIG_PHRASE_WIDTH / PIXEL_WIDTH are the default phrase and beat
//            widths.  lane_mask() builds the tkeep pattern for a phrase
//            whose highest populated lane is 'count'.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package stacker_pkg;

    localparam int MIG_PHRASE_WIDTH = 128;
    localparam int PIXEL_WIDTH      = 32;

    // Upper bound on lanes per phrase supported by lane_mask().
    localparam int MAX_LANES        = 256;

    // Lanes 0..count set, clipped to the n lanes a phrase actually has.
    function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned count,
                                                       input int unsigned n);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (i <= count && i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/phrase_stacker.sv
// ============================================================================
// Module   : phrase_stacker
// Purpose  : AXI-Stream width up-converter.  Packs N = OUT_WIDTH/IN_WIDTH
//            input beats into one output phrase, first beat in lane 0.
//            Sustains one input beat per cycle; only a completing beat can
//            be stalled, and only while the output slot is full and not
//            being drained.
// Macro    : STACKER_FLUSH_EN - when defined, a tlast beat closes a partial
//            phrase early (zero padded, tkeep marks valid lanes).  When
//            undefined, phrases close only when full and tkeep is all ones.
// Ports    : clk_in        sole clock
//            rst_in        synchronous, active-low reset
//            pixel_tvalid/pixel_tready/pixel_tdata/pixel_tlast   input beat
//            chunk_tvalid/chunk_tready/chunk_tdata/chunk_tkeep/chunk_tlast
//                          output phrase (registered slot)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module phrase_stacker
    import stacker_pkg::*;
#(
    parameter int IN_WIDTH  = PIXEL_WIDTH,
    parameter int OUT_WIDTH = MIG_PHRASE_WIDTH
) (
    input  logic                            clk_in,
    input  logic                            rst_in,

    input  logic                            pixel_tvalid,
    output logic                            pixel_tready,
    input  logic [IN_WIDTH-1:0]             pixel_tdata,
    input  logic                            pixel_tlast,

    output logic                            chunk_tvalid,
    input  logic                            chunk_tready,
    output logic [OUT_WIDTH-1:0]            chunk_tdata,
    output logic [OUT_WIDTH/IN_WIDTH-1:0]   chunk_tkeep,
    output logic                            chunk_tlast
);

    localparam int N  = OUT_WIDTH / IN_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (IN_WIDTH < 8 || (OUT_WIDTH % IN_WIDTH) != 0 || N < 2 || N > MAX_LANES) begin : g_param_check
            $error("phrase_stacker: OUT_WIDTH must be a multiple (>=2) of IN_WIDTH (>=8)");
        end
    endgenerate

    logic [CW-1:0]        count;
    logic [OUT_WIDTH-1:0] acc;
    logic                 last_seen;

    logic                 completing;
    logic                 accept;
    logic [OUT_WIDTH-1:0] phrase;
    logic [N-1:0]         keep;

    // ------------------------------------------------------------------
    // Phrase close condition and input handshake
    // ------------------------------------------------------------------
`ifdef STACKER_FLUSH_EN
    assign completing = (count == CW'(N - 1)) || pixel_tlast;
    assign keep       = N'(lane_mask(int'(count), N));
`else
    assign completing = (count == CW'(N - 1));
    assign keep       = '1;
`endif

    // Only the beat that would load the slot can be held off.
    assign pixel_tready = !completing || !chunk_tvalid || chunk_tready;
    assign accept       = pixel_tvalid && pixel_tready;

    // Accumulator with the current beat merged into lane 'count'.  Lanes
    // above 'count' are forced to zero so a flushed phrase is zero padded;
    // this value is also the next accumulator for non-completing beats.
    always_comb begin
        phrase = '0;
        for (int i = 0; i < N; i++) begin
            if (i == int'(count)) begin
                phrase[i*IN_WIDTH +: IN_WIDTH] = pixel_tdata;
            end else if (i < int'(count)) begin
                phrase[i*IN_WIDTH +: IN_WIDTH] = acc[i*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator, lane counter and output slot
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            count        <= '0;
            acc          <= '0;
            last_seen    <= 1'b0;
            chunk_tvalid <= 1'b0;
            chunk_tdata  <= '0;
            chunk_tkeep  <= '0;
            chunk_tlast  <= 1'b0;
        end else begin
            // Drain first; a load on the same edge below overrides this.
            if (chunk_tvalid && chunk_tready) begin
                chunk_tvalid <= 1'b0;
            end

            if (accept) begin
                if (completing) begin
                    chunk_tvalid <= 1'b1;
                    chunk_tdata  <= phrase;
                    chunk_tkeep  <= keep;
                    chunk_tlast  <= last_seen | pixel_tlast;
                    count        <= '0;
                    acc          <= '0;
                    last_seen    <= 1'b0;
                end else begin
                    count        <= count + CW'(1);
                    acc          <= phrase;
                    last_seen    <= last_seen | pixel_tlast;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_phrase_stacker.sv
// ============================================================================
// Module   : tb_phrase_stacker
// Purpose  : Self-checking bench for phrase_stacker.  A 32->128 instance is
//            covered by a background scoreboard plus directed tasks; a
//            16->128 instance checks the wider lane ratio.
// Macro    : STACKER_FLUSH_EN selects the expected early-flush behaviour.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_phrase_stacker;

    localparam int IW = 32;
    localparam int OW = 128;
    localparam int N  = OW / IW;
`ifdef STACKER_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;

    logic          pixel_tvalid = 1'b0;
    logic          pixel_tready;
    logic [IW-1:0] pixel_tdata  = '0;
    logic          pixel_tlast  = 1'b0;
    logic          chunk_tvalid;
    logic          chunk_tready = 1'b1;
    logic [OW-1:0] chunk_tdata;
    logic [N-1:0]  chunk_tkeep;
    logic          chunk_tlast;

    // 16 -> 128 instance
    logic          w16_tvalid = 1'b0;
    logic          w16_tready;
    logic [15:0]   w16_tdata  = '0;
    logic          w16_tlast  = 1'b0;
    logic          w16_cvalid;
    logic [127:0]  w16_cdata;
    logic [7:0]    w16_ckeep;
    logic          w16_clast;

    int total = 0;
    int bad   = 0;
    int rx_count = 0;

    always #5 clk_in = ~clk_in;

    phrase_stacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .pixel_tvalid (pixel_tvalid),
        .pixel_tready (pixel_tready),
        .pixel_tdata  (pixel_tdata),
        .pixel_tlast  (pixel_tlast),
        .chunk_tvalid (chunk_tvalid),
        .chunk_tready (chunk_tready),
        .chunk_tdata  (chunk_tdata),
        .chunk_tkeep  (chunk_tkeep),
        .chunk_tlast  (chunk_tlast)
    );

    phrase_stacker #(.IN_WIDTH(16), .OUT_WIDTH(128)) dut16 (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .pixel_tvalid (w16_tvalid),
        .pixel_tready (w16_tready),
        .pixel_tdata  (w16_tdata),
        .pixel_tlast  (w16_tlast),
        .chunk_tvalid (w16_cvalid),
        .chunk_tready (1'b1),
        .chunk_tdata  (w16_cdata),
        .chunk_tkeep  (w16_ckeep),
        .chunk_tlast  (w16_clast)
    );

    // ------------------------------------------------------------------
    // Reference model: a queue of beats in the open phrase and a queue of
    // phrases owed downstream.  Samples 2 time units after each falling
    // edge, once the stimulus for the coming rising edge is settled.
    // ------------------------------------------------------------------
    typedef struct {
        logic [OW-1:0] data;
        logic [N-1:0]  keep;
        logic          last;
    } phrase_t;

    logic [IW-1:0] lanes_q[$];
    logic          last_acc = 1'b0;
    phrase_t       exp_q[$];

    always begin
        @(negedge clk_in);
        #2;
        if (!rst_in) begin
            lanes_q.delete();
            exp_q.delete();
            last_acc = 1'b0;
        end else begin
            bit      exp_valid;
            bit      closing;
            bit      exp_ready;
            phrase_t p;

            exp_valid = (exp_q.size() != 0);
            total++;
            if (chunk_tvalid !== exp_valid) begin
                bad++;
                $display("FAIL sb_tvalid t=%0t got=%b want=%b", $time, chunk_tvalid, exp_valid);
            end
            if (exp_valid && chunk_tvalid === 1'b1) begin
                total++;
                if (chunk_tdata !== exp_q[0].data || chunk_tkeep !== exp_q[0].keep ||
                    chunk_tlast !== exp_q[0].last) begin
                    bad++;
                    $display("FAIL sb_phrase t=%0t got=%h/%h/%b want=%h/%h/%b", $time,
                             chunk_tdata, chunk_tkeep, chunk_tlast,
                             exp_q[0].data, exp_q[0].keep, exp_q[0].last);
                end
            end

            closing   = (lanes_q.size() == N - 1) || (FLUSH && pixel_tlast);
            exp_ready = !closing || !exp_valid || chunk_tready;
            total++;
            if (pixel_tready !== exp_ready) begin
                bad++;
                $display("FAIL sb_tready t=%0t got=%b want=%b", $time, pixel_tready, exp_ready);
            end

            if (chunk_tvalid === 1'b1 && chunk_tready && exp_valid) begin
                void'(exp_q.pop_front());
                rx_count++;
            end

            if (pixel_tvalid && pixel_tready === 1'b1) begin
                lanes_q.push_back(pixel_tdata);
                last_acc = last_acc | pixel_tlast;
                if (lanes_q.size() == N || (FLUSH && pixel_tlast)) begin
                    p.data = '0;
                    p.keep = '0;
                    for (int i = 0; i < lanes_q.size(); i++) begin
                        p.data[i*IW +: IW] = lanes_q[i];
                        p.keep[i]          = 1'b1;
                    end
                    p.last = last_acc;
                    exp_q.push_back(p);
                    lanes_q.delete();
                    last_acc = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic do_reset();
        @(negedge clk_in);
        pixel_tvalid = 1'b0;
        pixel_tlast  = 1'b0;
        w16_tvalid   = 1'b0;
        rst_in       = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in       = 1'b1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [IW-1:0] d, input logic l);
        int waitc;
        waitc = 0;
        @(negedge clk_in);
        pixel_tvalid = 1'b1;
        pixel_tdata  = d;
        pixel_tlast  = l;
        #1;
        while (pixel_tready !== 1'b1) begin
            waitc++;
            if (waitc > 50) begin
                total++;
                bad++;
                $display("FAIL send_timeout data=%h", d);
                break;
            end
            @(negedge clk_in);
            #1;
        end
    endtask

    task automatic idle();
        @(negedge clk_in);
        pixel_tvalid = 1'b0;
        pixel_tlast  = 1'b0;
        #1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if (chunk_tvalid !== 1'b0 || chunk_tdata !== '0 || chunk_tkeep !== '0 ||
            chunk_tlast !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%h/%h/%b want=0/0/0/0",
                     chunk_tvalid, chunk_tdata, chunk_tkeep, chunk_tlast);
        end
        total++;
        if (pixel_tready !== 1'b1) begin
            bad++;
            $display("FAIL reset_tready got=%b want=1", pixel_tready);
        end
    endtask

    task automatic test_basic();
        do_reset();
        chunk_tready = 1'b1;
        send(32'h11111111, 1'b0);
        send(32'h22222222, 1'b0);
        send(32'h33333333, 1'b0);
        idle();
        total++;
        if (chunk_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL basic_early_valid got=%b want=0", chunk_tvalid);
        end
        send(32'h44444444, 1'b0);
        idle();
        total++;
        if (chunk_tvalid !== 1'b1 || chunk_tdata !== 128'h44444444_33333333_22222222_11111111 ||
            chunk_tkeep !== 4'hF || chunk_tlast !== 1'b0) begin
            bad++;
            $display("FAIL basic_phrase got=%b/%h/%h/%b want=1/44444444333333332222222211111111/f/0",
                     chunk_tvalid, chunk_tdata, chunk_tkeep, chunk_tlast);
        end
        idle();
    endtask

    task automatic test_tlast();
        do_reset();
        chunk_tready = 1'b1;
        send(32'hAAAA0001, 1'b0);
        send(32'hBBBB0002, 1'b0);
        send(32'hCCCC0003, 1'b1);
`ifdef STACKER_FLUSH_EN
        idle();
        total++;
        if (chunk_tvalid !== 1'b1 || chunk_tdata !== 128'h00000000_CCCC0003_BBBB0002_AAAA0001 ||
            chunk_tkeep !== 4'h7 || chunk_tlast !== 1'b1) begin
            bad++;
            $display("FAIL flush_phrase got=%b/%h/%h/%b want=1/00000000cccc0003bbbb0002aaaa0001/7/1",
                     chunk_tvalid, chunk_tdata, chunk_tkeep, chunk_tlast);
        end
        send(32'hEEEE0005, 1'b0);
        send(32'hEEEE0006, 1'b0);
        send(32'hEEEE0007, 1'b0);
        send(32'hEEEE0008, 1'b0);
        idle();
        total++;
        if (chunk_tvalid !== 1'b1 || chunk_tdata !== 128'hEEEE0008_EEEE0007_EEEE0006_EEEE0005 ||
            chunk_tkeep !== 4'hF || chunk_tlast !== 1'b0) begin
            bad++;
            $display("FAIL flush_next_lane0 got=%b/%h/%h/%b want=1/eeee0008eeee0007eeee0006eeee0005/f/0",
                     chunk_tvalid, chunk_tdata, chunk_tkeep, chunk_tlast);
        end
`else
        send(32'hDDDD0004, 1'b0);
        idle();
        total++;
        if (chunk_tvalid !== 1'b1 || chunk_tdata !== 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001 ||
            chunk_tkeep !== 4'hF || chunk_tlast !== 1'b1) begin
            bad++;
            $display("FAIL noflush_phrase got=%b/%h/%h/%b want=1/dddd0004cccc0003bbbb0002aaaa0001/f/1",
                     chunk_tvalid, chunk_tdata, chunk_tkeep, chunk_tlast);
        end
`endif
        idle();
    endtask

    task automatic test_back_to_back();
        int sent;
        int rx0;
        int cyc;
        do_reset();
        rx0  = rx_count;
        sent = 0;
        cyc  = 0;
        chunk_tready = 1'b0;
        while (sent < 64 && cyc < 400) begin
            @(negedge clk_in);
            chunk_tready = ~chunk_tready;
            pixel_tvalid = 1'b1;
            pixel_tdata  = $urandom;
            pixel_tlast  = 1'b0;
            #1;
            while (pixel_tready !== 1'b1 && cyc < 400) begin
                @(negedge clk_in);
                chunk_tready = ~chunk_tready;
                cyc++;
                #1;
            end
            sent++;
            cyc++;
        end
        idle();
        chunk_tready = 1'b1;
        repeat (3) idle();
        total++;
        if (rx_count - rx0 != 16) begin
            bad++;
            $display("FAIL b2b_phrase_count got=%0d want=16", rx_count - rx0);
        end
    endtask

    task automatic test_reset_midphrase();
        do_reset();
        chunk_tready = 1'b0;
        send(32'h00000001, 1'b0);
        send(32'h00000002, 1'b0);
        send(32'h00000003, 1'b0);
        send(32'h00000004, 1'b0);
        send(32'h00000005, 1'b0);
        send(32'h00000006, 1'b0);
        @(negedge clk_in);
        pixel_tvalid = 1'b0;
        rst_in       = 1'b0;
        @(negedge clk_in);
        rst_in       = 1'b1;
        #1;
        total++;
        if (chunk_tvalid !== 1'b0 || chunk_tdata !== '0 || chunk_tkeep !== '0 ||
            chunk_tlast !== 1'b0 || pixel_tready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_outputs got=%b/%h/%h/%b rdy=%b want=0/0/0/0 rdy=1",
                     chunk_tvalid, chunk_tdata, chunk_tkeep, chunk_tlast, pixel_tready);
        end
        chunk_tready = 1'b1;
        send(32'h0000000A, 1'b0);
        send(32'h0000000B, 1'b0);
        send(32'h0000000C, 1'b0);
        send(32'h0000000D, 1'b0);
        idle();
        total++;
        if (chunk_tvalid !== 1'b1 || chunk_tdata !== 128'h0000000D_0000000C_0000000B_0000000A ||
            chunk_tkeep !== 4'hF || chunk_tlast !== 1'b0) begin
            bad++;
            $display("FAIL midreset_phrase got=%b/%h/%h/%b want=1/0000000d0000000c0000000b0000000a/f/0",
                     chunk_tvalid, chunk_tdata, chunk_tkeep, chunk_tlast);
        end
        idle();
    endtask

    task automatic test_random();
        bit pending;
        do_reset();
        pending = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_in);
            chunk_tready = ($urandom_range(0, 3) != 0);
            if (!pending && $urandom_range(0, 3) != 0) begin
                pending     = 1'b1;
                pixel_tdata = $urandom;
                pixel_tlast = ($urandom_range(0, 7) == 0);
            end
            if (!pending) pixel_tlast = 1'b0;
            pixel_tvalid = pending;
            #1;
            if (pending && pixel_tready === 1'b1) pending = 1'b0;
        end
        idle();
        chunk_tready = 1'b1;
        repeat (3) idle();
    endtask

    task automatic test_width16();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_in);
            w16_tvalid = 1'b1;
            w16_tdata  = 16'(i);
            #1;
            total++;
            if (w16_tready !== 1'b1) begin
                bad++;
                $display("FAIL w16_tready beat=%0d got=%b want=1", i, w16_tready);
            end
        end
        @(negedge clk_in);
        w16_tvalid = 1'b0;
        #1;
        total++;
        if (w16_cvalid !== 1'b1 || w16_cdata !== 128'h0008_0007_0006_0005_0004_0003_0002_0001 ||
            w16_ckeep !== 8'hFF || w16_clast !== 1'b0) begin
            bad++;
            $display("FAIL w16_phrase got=%b/%h/%h/%b want=1/00080007000600050004000300020001/ff/0",
                     w16_cvalid, w16_cdata, w16_ckeep, w16_clast);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tlast();
        test_back_to_back();
        test_reset_midphrase();
        test_random();
        test_width16();
        repeat (2) @(negedge clk_in);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
